shift_deser: RTL

//   Serial-to-parallel receiver, the far end of the parallel-load/serial-out shift link.

---
 rtl/shift_deser.sv | 104 ++++++++++
 1 files changed

// File: rtl/shift_deser.sv
// Serial-to-parallel receiver: collects qualified serial bits into a word and hands it off via valid/ready.
// Optional feature: define SHIFT_DESER_PARITY_EN to append and check one even-parity bit per frame.
module shift_deser #(
    parameter int unsigned SHIFT_WIDTH     = 4,
    parameter string       SHIFT_DIRECTION = "LEFT"
) (
    input  logic                   clk,
    input  logic                   aclr_n,
    input  logic                   sclr,
    input  logic                   sync,
    input  logic                   en,
    input  logic                   shiftin,
    input  logic                   q_ready,
    output logic [SHIFT_WIDTH-1:0] q,
    output logic                   q_valid,
    output logic                   overrun,
`ifdef SHIFT_DESER_PARITY_EN
    output logic                   parity_err,
`endif
    output logic                   busy
);

    localparam int unsigned W = SHIFT_WIDTH;
`ifdef SHIFT_DESER_PARITY_EN
    localparam int unsigned F = W + 1;
`else
    localparam int unsigned F = W;
`endif
    localparam int unsigned CW       = $clog2(F + 1);
    localparam bit          DIR_LEFT = (SHIFT_DIRECTION == "LEFT");

    logic [F-1:0]  sreg;
    logic [F-1:0]  sreg_shift;
    logic [CW-1:0] bit_cnt;
    logic [CW-1:0] cnt_nxt;
    logic [W-1:0]  word;
    logic          done;

    // Shifted image includes the bit sampled at this edge, so the word is complete on the last bit.
    always_comb begin
        sreg_shift = sreg;
        word       = '0;
        done       = 1'b0;
        cnt_nxt    = bit_cnt;
        if (DIR_LEFT) begin
            sreg_shift = {sreg[F-2:0], shiftin};
            word       = sreg_shift[F-1 -: W];
        end else begin
            sreg_shift = {shiftin, sreg[F-1:1]};
            word       = sreg_shift[W-1:0];
        end
        done = en && !sync && (bit_cnt == CW'(F - 1));
        if (sync) begin
            cnt_nxt = en ? CW'(1) : '0;
        end else if (en) begin
            cnt_nxt = done ? '0 : bit_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            sreg       <= '0;
            bit_cnt    <= '0;
            busy       <= 1'b0;
            q          <= '0;
            q_valid    <= 1'b0;
            overrun    <= 1'b0;
`ifdef SHIFT_DESER_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else if (sclr) begin
            sreg       <= '0;
            bit_cnt    <= '0;
            busy       <= 1'b0;
            q          <= '0;
            q_valid    <= 1'b0;
            overrun    <= 1'b0;
`ifdef SHIFT_DESER_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            if (en) begin
                sreg <= sreg_shift;
            end
            bit_cnt <= cnt_nxt;
            busy    <= (cnt_nxt != '0);
            // A finished word only replaces q when the slot is free or being consumed this edge.
            if (done) begin
                if (!q_valid || q_ready) begin
                    q          <= word;
                    q_valid    <= 1'b1;
`ifdef SHIFT_DESER_PARITY_EN
                    parity_err <= ^sreg_shift;
`endif
                end else begin
                    overrun <= 1'b1;
                end
            end else if (q_valid && q_ready) begin
                q_valid <= 1'b0;
            end
        end
    end

endmodule
